// File: rtl/noc_types.sv
// Shared mesh-network types: packet layout, default widths
// and a saturating counter helper.
package noc_types;

    localparam int NOC_COORD_WIDTH = 4;
    localparam int NOC_DATA_WIDTH  = 8;

    typedef struct packed {
        logic [NOC_COORD_WIDTH-1:0] dest_x;
        logic [NOC_COORD_WIDTH-1:0] dest_y;
        logic [NOC_COORD_WIDTH-1:0] src_x;
        logic [NOC_COORD_WIDTH-1:0] src_y;
        logic [NOC_DATA_WIDTH-1:0]  data;
    } packet_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy counter drives full/empty
// so the flags are purely registered.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mesh_endpoint.sv
// Mesh edge endpoint: packs local sends into packets, filters
// inbound packets by destination and counts delivered/dropped ones.
module mesh_endpoint
    import noc_types::*;
#(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int COORD_WIDTH = NOC_COORD_WIDTH,
    parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic [COORD_WIDTH-1:0]         tx_dest_x,
    input  logic [COORD_WIDTH-1:0]         tx_dest_y,
    input  logic [DATA_WIDTH-1:0]          tx_data,
    output logic                           net_out_valid,
    input  logic                           net_out_ready,
    output logic [4*COORD_WIDTH+DATA_WIDTH-1:0] net_out_packet,
    input  logic                           net_in_valid,
    output logic                           net_in_ready,
    input  logic [4*COORD_WIDTH+DATA_WIDTH-1:0] net_in_packet,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [DATA_WIDTH-1:0]          rx_data,
    output logic [COORD_WIDTH-1:0]         rx_src_x,
    output logic [COORD_WIDTH-1:0]         rx_src_y,
    output logic [15:0]                    rx_count,
    output logic [15:0]                    drop_count
);

    localparam int CW = COORD_WIDTH;
    localparam int PW = 4*CW + DATA_WIDTH;
    localparam int RW = 2*CW + DATA_WIDTH;

    localparam logic [CW-1:0] OWN_X = CW'(X);
    localparam logic [CW-1:0] OWN_Y = CW'(Y);

    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;
    logic [PW-1:0] tx_packet;

    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;
    logic          in_accept;
    logic          in_hit;
    logic [CW-1:0] in_dest_x;
    logic [CW-1:0] in_dest_y;
    logic [RW-1:0] rx_head;

    assign tx_ready      = ~tx_full;
    assign net_out_valid = ~tx_empty;
    assign tx_push       = tx_valid & tx_ready;
    assign tx_pop        = net_out_valid & net_out_ready;
    assign tx_packet     = {tx_dest_x, tx_dest_y, OWN_X, OWN_Y, tx_data};

    sync_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_packet),
        .pop       (tx_pop),
        .pop_data  (net_out_packet),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign in_dest_x    = net_in_packet[PW-1 -: CW];
    assign in_dest_y    = net_in_packet[PW-CW-1 -: CW];
    assign in_hit       = (in_dest_x == OWN_X) && (in_dest_y == OWN_Y);
    assign net_in_ready = ~rx_full;
    assign in_accept    = net_in_valid & net_in_ready;
    assign rx_push      = in_accept & in_hit;
    assign rx_valid     = ~rx_empty;
    assign rx_pop       = rx_valid & rx_ready;

    sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (net_in_packet[RW-1:0]),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_src_x = rx_head[RW-1 -: CW];
    assign rx_src_y = rx_head[RW-CW-1 -: CW];
    assign rx_data  = rx_head[DATA_WIDTH-1:0];

    // Saturating statistics for delivered and misrouted packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else if (in_accept) begin
            if (in_hit)
                rx_count <= sat_inc16(rx_count);
            else
                drop_count <= sat_inc16(drop_count);
        end
    end

endmodule

// File: tb/tb_mesh_endpoint.sv
// Directed bench for mesh_endpoint at X=0, Y=1 with depth-4 FIFOs.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mesh_endpoint;
    import noc_types::*;

    localparam int CW = 4;
    localparam int DW = 8;
    localparam int PW = 4*CW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic [CW-1:0] tx_dest_x;
    logic [CW-1:0] tx_dest_y;
    logic [DW-1:0] tx_data;
    logic          net_out_valid;
    logic          net_out_ready;
    logic [PW-1:0] net_out_packet;
    logic          net_in_valid;
    logic          net_in_ready;
    logic [PW-1:0] net_in_packet;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] rx_src_x;
    logic [CW-1:0] rx_src_y;
    logic [15:0]   rx_count;
    logic [15:0]   drop_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mesh_endpoint #(
        .X(0), .Y(1), .COORD_WIDTH(CW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_dest_x      (tx_dest_x),
        .tx_dest_y      (tx_dest_y),
        .tx_data        (tx_data),
        .net_out_valid  (net_out_valid),
        .net_out_ready  (net_out_ready),
        .net_out_packet (net_out_packet),
        .net_in_valid   (net_in_valid),
        .net_in_ready   (net_in_ready),
        .net_in_packet  (net_in_packet),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_src_x       (rx_src_x),
        .rx_src_y       (rx_src_y),
        .rx_count       (rx_count),
        .drop_count     (drop_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input int dx, input int dy,
                                         input int sx, input int sy,
                                         input int d);
        packet_t p;
        p.dest_x = CW'(dx);
        p.dest_y = CW'(dy);
        p.src_x  = CW'(sx);
        p.src_y  = CW'(sy);
        p.data   = DW'(d);
        return p;
    endfunction

    task automatic check_idle(input string tag);
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s tx_ready got %b want 1", tag, tx_ready);
        end
        tests++;
        if (net_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s net_in_ready got %b want 1", tag, net_in_ready);
        end
        tests++;
        if (net_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s net_out_valid got %b want 0", tag, net_out_valid);
        end
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s rx_valid got %b want 0", tag, rx_valid);
        end
        tests++;
        if (rx_count !== 16'd0) begin
            fails++;
            $display("FAIL %s rx_count got %h want 0", tag, rx_count);
        end
        tests++;
        if (drop_count !== 16'd0) begin
            fails++;
            $display("FAIL %s drop_count got %h want 0", tag, drop_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_dest_x = '0;
        tx_dest_y = '0;
        tx_data = '0;
        net_out_ready = 1'b0;
        net_in_valid = 1'b0;
        net_in_packet = '0;
        rx_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check_idle("reset");
    endtask

    task automatic test_single_send();
        net_out_ready = 1'b1;
        tx_valid = 1'b1;
        tx_dest_x = 4'd2;
        tx_dest_y = 4'd1;
        tx_data = 8'hA5;
        step();
        tx_valid = 1'b0;
        tests++;
        if (net_out_valid !== 1'b1 || net_out_packet !== 24'h2101A5) begin
            fails++;
            $display("FAIL single_send v=%b pkt=%h want v=1 pkt=2101a5",
                     net_out_valid, net_out_packet);
        end
        step();
        tests++;
        if (net_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_send_once v=%b want 0", net_out_valid);
        end
    endtask

    task automatic test_tx_backpressure();
        net_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_dest_x = 4'd3;
            tx_dest_y = CW'(i);
            tx_data = DW'(8'h10 + i);
            tests++;
            if (tx_ready !== (i < 4)) begin
                fails++;
                $display("FAIL tx_ready_fill[%0d] got %b want %b",
                         i, tx_ready, (i < 4));
            end
            step();
        end
        tx_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tests++;
            if (net_out_valid !== 1'b1 || net_out_packet !== mk(3, 0, 0, 1, 8'h10)) begin
                fails++;
                $display("FAIL stall_hold[%0d] v=%b pkt=%h want v=1 pkt=%h",
                         s, net_out_valid, net_out_packet, mk(3, 0, 0, 1, 8'h10));
            end
            step();
        end
        net_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (net_out_valid !== 1'b1 || net_out_packet !== mk(3, i, 0, 1, 8'h10 + i)) begin
                fails++;
                $display("FAIL drain[%0d] v=%b pkt=%h want v=1 pkt=%h",
                         i, net_out_valid, net_out_packet, mk(3, i, 0, 1, 8'h10 + i));
            end
            step();
        end
        tests++;
        if (net_out_valid !== 1'b0 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty v=%b rdy=%b want v=0 rdy=1",
                     net_out_valid, tx_ready);
        end
        net_out_ready = 1'b0;
    endtask

    task automatic test_rx_filter();
        rx_ready = 1'b0;
        net_in_valid = 1'b1;
        net_in_packet = mk(0, 1, 2, 2, 8'h3C);
        step();
        net_in_packet = mk(3, 3, 1, 1, 8'h77);
        step();
        net_in_valid = 1'b0;
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C ||
            rx_src_x !== 4'd2 || rx_src_y !== 4'd2) begin
            fails++;
            $display("FAIL rx_head v=%b d=%h sx=%0d sy=%0d want 1 3c 2 2",
                     rx_valid, rx_data, rx_src_x, rx_src_y);
        end
        tests++;
        if (rx_count !== 16'd1 || drop_count !== 16'd1) begin
            fails++;
            $display("FAIL rx_counts rx=%0d drop=%0d want 1 1",
                     rx_count, drop_count);
        end
        rx_ready = 1'b1;
        step();
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_drop_hidden v=%b d=%h want v=0", rx_valid, rx_data);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_rx_full();
        logic [DW-1:0] q[$];
        int exp_rx;
        int nxt;
        exp_rx = 1;
        nxt = 8'h40;
        net_in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic do_push;
            logic do_pop;
            rx_ready = (c >= 6 && c < 12);
            net_in_valid = (c < 10);
            net_in_packet = mk(0, 1, 5, 6, nxt);
            tests++;
            if (net_in_ready !== (q.size() != 4) ||
                rx_valid !== (q.size() != 0) ||
                rx_count !== 16'(exp_rx)) begin
                fails++;
                $display("FAIL rx_full[%0d] in_rdy=%b rx_v=%b cnt=%0d want %b %b %0d",
                         c, net_in_ready, rx_valid, rx_count,
                         (q.size() != 4), (q.size() != 0), exp_rx);
            end
            if (q.size() != 0) begin
                tests++;
                if (rx_data !== q[0]) begin
                    fails++;
                    $display("FAIL rx_full_data[%0d] got %h want %h", c, rx_data, q[0]);
                end
            end
            do_push = net_in_valid && (q.size() != 4);
            do_pop = rx_ready && (q.size() != 0);
            step();
            if (do_pop)
                void'(q.pop_front());
            if (do_push) begin
                q.push_back(DW'(nxt));
                nxt++;
                exp_rx++;
            end
        end
        rx_ready = 1'b0;
        net_in_valid = 1'b0;
    endtask

    task automatic test_saturate_and_reset();
        rx_ready = 1'b1;
        step();
        step();
        rx_ready = 1'b0;
        net_in_valid = 1'b1;
        net_in_packet = mk(5, 5, 1, 1, 8'h99);
        for (int i = 0; i < 65537; i++)
            step();
        net_in_valid = 1'b0;
        tests++;
        if (drop_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL drop_saturate got %h want ffff", drop_count);
        end
        step();
        tests++;
        if (drop_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL drop_hold got %h want ffff", drop_count);
        end
        net_out_ready = 1'b0;
        tx_valid = 1'b1;
        tx_dest_x = 4'd7;
        tx_dest_y = 4'd7;
        tx_data = 8'hEE;
        net_in_valid = 1'b1;
        net_in_packet = mk(0, 1, 3, 3, 8'h55);
        step();
        rst = 1'b1;
        step();
        check_idle("mid_reset");
        tx_valid = 1'b0;
        net_in_valid = 1'b0;
        rst = 1'b0;
        step();
        step();
        check_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_tx_backpressure();
        test_rx_filter();
        test_rx_full();
        test_saturate_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
